// File: rtl/mips_pkg.sv
// Shared opcode map, instruction classes and forward-select encoding for the
// five-stage MIPS32-subset pipeline.
package mips_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT} instr_type_t;

   typedef enum logic [1:0] {FWD_ID_EX, FWD_EX_MEM, FWD_MEM_WB} fwd_sel_t;

   // Unknown opcodes, and MUL on a core built without a multiplier, stop the core.
   function automatic instr_type_t decode_type(input logic [5:0] op, input logic mul_en);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: decode_type = RR_ALU;
         OP_MUL:                                decode_type = mul_en ? RR_ALU : HALT;
         OP_ADDI, OP_SUBI, OP_SLTI:             decode_type = RM_ALU;
         OP_LW:                                 decode_type = LOAD;
         OP_SW:                                 decode_type = STORE;
         OP_BNEQZ, OP_BEQZ:                     decode_type = BRANCH;
         default:                               decode_type = HALT;
      endcase
   endfunction

endpackage

// File: rtl/mips_pipe_core_hazard.sv
// Combinational hazard unit: EX operand forwarding, load-use stall, branch
// flush and halt freeze, with flush taking priority over the other two.
module mips_hazard_unit
   import mips_pkg::*;
(
   input  logic        id_valid,
   input  instr_type_t id_type,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        ex_valid,
   input  instr_type_t ex_type,
   input  logic [4:0]  ex_rs,
   input  logic [4:0]  ex_rt,
   input  logic        mem_wr,
   input  logic [4:0]  mem_dest,
   input  logic        wb_wr,
   input  logic [4:0]  wb_dest,
   input  logic        branch_taken,
   input  logic        halt_in_flight,
   output fwd_sel_t    fwd_a,
   output fwd_sel_t    fwd_b,
   output logic        stall,
   output logic        flush,
   output logic        freeze
);
   logic uses_rs, uses_rt, load_use;

   // mem_wr/wb_wr already exclude R0 destinations, so R0 never forwards.
   assign fwd_a = (mem_wr && mem_dest == ex_rs) ? FWD_EX_MEM :
                  (wb_wr  && wb_dest  == ex_rs) ? FWD_MEM_WB : FWD_ID_EX;
   assign fwd_b = (mem_wr && mem_dest == ex_rt) ? FWD_EX_MEM :
                  (wb_wr  && wb_dest  == ex_rt) ? FWD_MEM_WB : FWD_ID_EX;

   assign uses_rs  = (id_type != HALT);
   assign uses_rt  = (id_type == RR_ALU) || (id_type == STORE);
   assign load_use = ex_valid && (ex_type == LOAD) && (ex_rt != 5'd0) && id_valid &&
                     ((uses_rs && id_rs == ex_rt) || (uses_rt && id_rt == ex_rt));

   assign flush  = branch_taken;
   assign stall  = load_use && !flush;
   assign freeze = !flush && (halt_in_flight || (id_valid && id_type == HALT));

endmodule

// File: rtl/mips_pipe_core.sv
// Five-stage MIPS32-subset pipeline (IF, ID, EX, MEM, WB) with forwarding,
// load-use interlock, branch flush in EX and a sticky halt.
module mips_pipe_core
   import mips_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PC_W   = 10,
   parameter bit MUL_EN = 1'b1,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [PC_W-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   output logic             dmem_we,
   input  logic [XLEN-1:0]  dmem_rdata,
   input  logic [4:0]       dbg_raddr,
   output logic [XLEN-1:0]  dbg_rdata,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);
   logic [XLEN-1:0] regs [32];

   logic [PC_W-1:0] pc;
   logic            if_id_valid;
   logic [31:0]     if_id_ir;
   logic [PC_W-1:0] if_id_npc;

   logic            id_ex_valid, id_ex_we;
   instr_type_t     id_ex_type;
   logic [5:0]      id_ex_op;
   logic [XLEN-1:0] id_ex_a, id_ex_b, id_ex_imm;
   logic [4:0]      id_ex_rs, id_ex_rt, id_ex_dest;
   logic [PC_W-1:0] id_ex_npc;

   logic            ex_mem_valid, ex_mem_we, ex_mem_load, ex_mem_store, ex_mem_halt;
   logic [XLEN-1:0] ex_mem_alu, ex_mem_sdata;
   logic [4:0]      ex_mem_dest;

   logic            mem_wb_valid, mem_wb_we, mem_wb_halt;
   logic [XLEN-1:0] mem_wb_result;
   logic [4:0]      mem_wb_dest;

   logic [5:0]         id_op;
   logic [4:0]         id_rs, id_rt, id_rd;
   instr_type_t        id_type;
   logic signed [15:0] id_simm;
   logic [XLEN-1:0]    id_imm, id_a, id_b;

   logic [XLEN-1:0] op_a, op_b, alu_b, alu, mem_result;
   logic [PC_W-1:0] br_target;
   logic            branch_taken, mem_wr, wb_wr, halt_in_flight;
   logic            stall, flush, freeze;
   fwd_sel_t        fwd_a, fwd_b;

   assign id_op   = if_id_ir[31:26];
   assign id_rs   = if_id_ir[25:21];
   assign id_rt   = if_id_ir[20:16];
   assign id_rd   = if_id_ir[15:11];
   assign id_simm = if_id_ir[15:0];
   assign id_imm  = XLEN'(id_simm);
   assign id_type = decode_type(id_op, MUL_EN);

   assign mem_wr = ex_mem_valid && ex_mem_we && (ex_mem_dest != 5'd0);
   assign wb_wr  = mem_wb_valid && mem_wb_we && (mem_wb_dest != 5'd0);

   // Register reads see the value being written back in the same cycle.
   assign id_a = (id_rs == 5'd0) ? '0 : (wb_wr && mem_wb_dest == id_rs) ? mem_wb_result : regs[id_rs];
   assign id_b = (id_rt == 5'd0) ? '0 : (wb_wr && mem_wb_dest == id_rt) ? mem_wb_result : regs[id_rt];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
      op_a = id_ex_a;
      op_b = id_ex_b;
      case (fwd_a)
         FWD_EX_MEM: op_a = ex_mem_alu;
         FWD_MEM_WB: op_a = mem_wb_result;
         default:    ;
      endcase
      case (fwd_b)
         FWD_EX_MEM: op_b = ex_mem_alu;
         FWD_MEM_WB: op_b = mem_wb_result;
         default:    ;
      endcase
      alu_b = (id_ex_type == RR_ALU) ? op_b : id_ex_imm;
      alu   = op_a + alu_b;
      case (id_ex_op)
         OP_SUB, OP_SUBI: alu = op_a - alu_b;
         OP_AND:          alu = op_a & alu_b;
         OP_OR:           alu = op_a | alu_b;
         OP_SLT, OP_SLTI: alu = XLEN'(op_a < alu_b);
         OP_MUL:          alu = op_a * alu_b;
         default:         ;
      endcase
   end

   assign branch_taken = id_ex_valid && (id_ex_type == BRANCH) &&
                         ((id_ex_op == OP_BEQZ) == (op_a == '0));
   assign br_target    = id_ex_npc + id_ex_imm[PC_W-1:0];

   assign mem_result = ex_mem_load ? dmem_rdata : ex_mem_alu;
   assign halt_in_flight = (id_ex_valid && id_ex_type == HALT) ||
                           (ex_mem_valid && ex_mem_halt) || (mem_wb_valid && mem_wb_halt);

   assign imem_addr  = pc;
   assign dmem_addr  = ex_mem_alu[PC_W-1:0];
   assign dmem_wdata = ex_mem_sdata;
   assign dmem_we    = ex_mem_valid && ex_mem_store && !halted;
   assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

   mips_hazard_unit u_hazard (
      .id_valid       (if_id_valid),
      .id_type        (id_type),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .ex_valid       (id_ex_valid),
      .ex_type        (id_ex_type),
      .ex_rs          (id_ex_rs),
      .ex_rt          (id_ex_rt),
      .mem_wr         (mem_wr),
      .mem_dest       (ex_mem_dest),
      .wb_wr          (wb_wr),
      .wb_dest        (mem_wb_dest),
      .branch_taken   (branch_taken),
      .halt_in_flight (halt_in_flight),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .stall          (stall),
      .flush          (flush),
      .freeze         (freeze)
   );

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= '0;
         if_id_valid   <= 1'b0;
         if_id_ir      <= '0;
         if_id_npc     <= '0;
         id_ex_valid   <= 1'b0;
         id_ex_we      <= 1'b0;
         id_ex_type    <= RR_ALU;
         id_ex_op      <= '0;
         id_ex_a       <= '0;
         id_ex_b       <= '0;
         id_ex_imm     <= '0;
         id_ex_rs      <= '0;
         id_ex_rt      <= '0;
         id_ex_dest    <= '0;
         id_ex_npc     <= '0;
         ex_mem_valid  <= 1'b0;
         ex_mem_we     <= 1'b0;
         ex_mem_load   <= 1'b0;
         ex_mem_store  <= 1'b0;
         ex_mem_halt   <= 1'b0;
         ex_mem_alu    <= '0;
         ex_mem_sdata  <= '0;
         ex_mem_dest   <= '0;
         mem_wb_valid  <= 1'b0;
         mem_wb_we     <= 1'b0;
         mem_wb_halt   <= 1'b0;
         mem_wb_result <= '0;
         mem_wb_dest   <= '0;
         halted        <= 1'b0;
         instret       <= '0;
      end else if (!halted) begin
         if (flush) begin
            pc          <= br_target;
            if_id_valid <= 1'b0;
         end else if (freeze) begin
            if_id_valid <= 1'b0;
         end else if (!stall) begin
            pc          <= pc + PC_W'(1);
            if_id_valid <= 1'b1;
            if_id_ir    <= imem_rdata;
            if_id_npc   <= pc + PC_W'(1);
         end

         id_ex_valid <= if_id_valid && !flush && !stall;
         id_ex_type  <= id_type;
         id_ex_op    <= id_op;
         id_ex_a     <= id_a;
         id_ex_b     <= id_b;
         id_ex_imm   <= id_imm;
         id_ex_rs    <= id_rs;
         id_ex_rt    <= id_rt;
         id_ex_npc   <= if_id_npc;
         id_ex_dest  <= (id_type == RR_ALU) ? id_rd : id_rt;
         id_ex_we    <= (id_type == RR_ALU) || (id_type == RM_ALU) || (id_type == LOAD);

         ex_mem_valid <= id_ex_valid;
         ex_mem_we    <= id_ex_we;
         ex_mem_load  <= (id_ex_type == LOAD);
         ex_mem_store <= (id_ex_type == STORE);
         ex_mem_halt  <= (id_ex_type == HALT);
         ex_mem_alu   <= alu;
         ex_mem_sdata <= op_b;
         ex_mem_dest  <= id_ex_dest;

         mem_wb_valid  <= ex_mem_valid;
         mem_wb_we     <= ex_mem_we;
         mem_wb_halt   <= ex_mem_halt;
         mem_wb_result <= mem_result;
         mem_wb_dest   <= ex_mem_dest;

         halted  <= mem_wb_valid && mem_wb_halt;
         instret <= instret + CNT_W'(mem_wb_valid);
      end
   end

   // NOTE: the register file is an array but still takes the async reset, since software relies on all-zero registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_wr && !halted) begin
         regs[mem_wb_dest] <= mem_wb_result;
      end
   end

endmodule

// File: tb/tb_mips_pipe_core.sv
// Program-level bench for mips_pipe_core: table of small programs with expected
// registers, halt timing, retire counts and stores, plus a mid-run reset sequence.
module tb_mips_pipe_core;
   import mips_pkg::*;

   localparam int XLEN  = 32;
   localparam int PC_W  = 10;
   localparam int CNT_W = 32;
   localparam logic [31:0] HLT_W = {OP_HLT, 26'd0};

   logic             clk = 1'b0;
   logic             rst;
   logic [PC_W-1:0]  imem_addr;
   logic [31:0]      imem_rdata;
   logic [PC_W-1:0]  dmem_addr;
   logic [XLEN-1:0]  dmem_wdata;
   logic             dmem_we;
   logic [XLEN-1:0]  dmem_rdata;
   logic [4:0]       dbg_raddr;
   logic [XLEN-1:0]  dbg_rdata;
   logic             halted;
   logic [CNT_W-1:0] instret;

   logic [31:0]   imem [1024];
   logic [XLEN-1:0] dmem [1024];

   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   always #5 clk = ~clk;

   mips_pipe_core #(.XLEN(XLEN), .PC_W(PC_W), .MUL_EN(1'b1), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_rdata (dmem_rdata),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata),
      .halted     (halted),
      .instret    (instret)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Store observer: records every dmem_we pulse for the scoreboard.
   int              n_obs;
   logic [PC_W-1:0] obs_addr [8];
   logic [XLEN-1:0] obs_data [8];
   always @(negedge clk or posedge rst) begin
      if (rst) n_obs <= 0;
      else if (dmem_we) begin
         if (n_obs < 8) begin
            obs_addr[n_obs] <= dmem_addr;
            obs_data[n_obs] <= dmem_wdata;
         end
         n_obs <= n_obs + 1;
      end
   end

   typedef struct packed {
      logic [PC_W-1:0] a;
      logic [XLEN-1:0] d;
   } st_t;
   st_t exp_q [$];

   typedef struct {
      int               base;
      int               len;
      int               halt_edge;
      int               ret;
      int               nchk;
      logic [3:0][4:0]  r;
      logic [3:0][31:0] v;
      int               nst;
      logic [PC_W-1:0]  st_addr;
      logic [31:0]      st_data;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] rom [64];
   int          rp = 0;
   int          nv = 0;

   function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic emit(input logic [31:0] w);
      rom[rp] = w;
      rp++;
   endtask

   task automatic open_vec();
      vecs[nv].base = rp;
      vecs[nv].nchk = 0;
      vecs[nv].nst  = 0;
   endtask

   task automatic want_reg(input int r, input logic [31:0] v);
      vecs[nv].r[vecs[nv].nchk] = 5'(r);
      vecs[nv].v[vecs[nv].nchk] = v;
      vecs[nv].nchk++;
   endtask

   task automatic want_st(input int a, input logic [31:0] d);
      vecs[nv].nst     = 1;
      vecs[nv].st_addr = PC_W'(a);
      vecs[nv].st_data = d;
   endtask

   task automatic close_vec(input int halt_edge, input int ret);
      vecs[nv].len       = rp - vecs[nv].base;
      vecs[nv].halt_edge = halt_edge;
      vecs[nv].ret       = ret;
      nv++;
   endtask

   task automatic clear_mem();
      for (int k = 0; k < 1024; k++) begin
         imem[k] = HLT_W;
         dmem[k] = '0;
      end
      dmem[100] = 32'd7;
   endtask

   task automatic wait_halt(output int edges, output bit done);
      edges = 0;
      done  = 1'b0;
      while (!done && edges < 300) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         done = halted;
      end
   endtask

   task automatic read_reg(input string nm, input int r, input logic [31:0] v);
      dbg_raddr = 5'(r);
      #1;
      check(nm, dbg_rdata, v);
   endtask

   task automatic run_vec(input int i);
      int  edges;
      bit  done;
      int  k;
      st_t st;
      clear_mem();
      for (int j = 0; j < vecs[i].len; j++) imem[j] = rom[vecs[i].base + j];
      if (vecs[i].nst > 0) exp_q.push_back({vecs[i].st_addr, vecs[i].st_data});

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_rst_halted", i), halted, 0);
      check($sformatf("v%0d_rst_instret", i), instret, 0);
      check($sformatf("v%0d_rst_pc", i), imem_addr, 0);
      check($sformatf("v%0d_rst_we", i), dmem_we, 0);
      rst = 1'b0;

      wait_halt(edges, done);
      check($sformatf("v%0d_halted", i), done, 1);
      if (vecs[i].halt_edge > 0) check($sformatf("v%0d_halt_edge", i), edges, vecs[i].halt_edge);
      check($sformatf("v%0d_instret", i), instret, vecs[i].ret);

      repeat (3) @(negedge clk);
      check($sformatf("v%0d_instret_frozen", i), instret, vecs[i].ret);
      check($sformatf("v%0d_we_after_halt", i), dmem_we, 0);

      for (int j = 0; j < vecs[i].nchk; j++)
         read_reg($sformatf("v%0d_R%0d", i, vecs[i].r[j]), int'(vecs[i].r[j]), vecs[i].v[j]);

      check($sformatf("v%0d_store_count", i), n_obs, vecs[i].nst);
      k = 0;
      while (exp_q.size() > 0) begin
         st = exp_q.pop_front();
         if (k < n_obs && k < 8) begin
            check($sformatf("v%0d_store_addr", i), obs_addr[k], st.a);
            check($sformatf("v%0d_store_data", i), obs_data[k], st.d);
         end
         k++;
      end
   endtask

   task automatic run_reset_midrun();
      int edges;
      bit done;
      clear_mem();
      imem[0] = ri(OP_ADDI, 1, 0, 3);
      imem[1] = ri(OP_SUBI, 1, 1, 1);
      imem[2] = ri(OP_BNEQZ, 0, 1, -2);
      imem[3] = ri(OP_ADDI, 2, 0, 7);
      imem[4] = HLT_W;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("rm_pre_instret", instret, 2);
      check("rm_pre_halted", halted, 0);

      rst = 1'b1;
      #1;
      check("rm_rst_halted", halted, 0);
      check("rm_rst_instret", instret, 0);
      check("rm_rst_pc", imem_addr, 0);
      check("rm_rst_we", dmem_we, 0);
      read_reg("rm_rst_R1", 1, 0);

      @(negedge clk);
      rst = 1'b0;
      wait_halt(edges, done);
      check("rm_halted", done, 1);
      check("rm_halt_edge", edges, 17);
      check("rm_instret", instret, 9);
      read_reg("rm_R1", 1, 0);
      read_reg("rm_R2", 2, 7);
   endtask

   initial begin
      rst       = 1'b1;
      dbg_raddr = '0;

      // basic program
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 10)); emit(ri(OP_ADDI, 2, 0, 20)); emit(rr(OP_ADD, 3, 1, 2)); emit(HLT_W);
      want_reg(1, 10); want_reg(2, 20); want_reg(3, 30);
      close_vec(8, 4);

      // back-to-back forwarding, no stalls
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 5)); emit(rr(OP_ADD, 2, 1, 1)); emit(rr(OP_SUB, 3, 2, 1)); emit(HLT_W);
      want_reg(1, 5); want_reg(2, 10); want_reg(3, 5);
      close_vec(8, 4);

      // load-use: exactly one bubble
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 100)); emit(ri(OP_LW, 2, 1, 0)); emit(rr(OP_ADD, 3, 2, 2)); emit(HLT_W);
      want_reg(2, 7); want_reg(3, 14);
      close_vec(9, 4);

      // taken branch flushes two younger instructions
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 0)); emit(ri(OP_BEQZ, 0, 1, 2)); emit(ri(OP_ADDI, 4, 0, 1));
      emit(ri(OP_ADDI, 5, 0, 1)); emit(ri(OP_ADDI, 6, 0, 3)); emit(HLT_W);
      want_reg(4, 0); want_reg(5, 0); want_reg(6, 3);
      close_vec(10, 4);

      // store with R0 write discarded
      open_vec();
      emit(ri(OP_ADDI, 0, 0, 9)); emit(ri(OP_ADDI, 1, 0, 42)); emit(ri(OP_SW, 1, 0, 200)); emit(HLT_W);
      want_reg(0, 0); want_reg(1, 42); want_st(200, 42);
      close_vec(8, 4);

      // illegal opcode halts like HLT
      open_vec();
      emit(ri(OP_ADDI, 0, 0, 9)); emit(ri(OP_ADDI, 1, 0, 42)); emit(ri(OP_SW, 1, 0, 200)); emit({6'b010101, 26'd0});
      want_reg(0, 0); want_reg(1, 42); want_st(200, 42);
      close_vec(8, 4);

      // MUL and unsigned compares
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 6)); emit(ri(OP_ADDI, 2, 0, 7)); emit(rr(OP_MUL, 3, 1, 2)); emit(rr(OP_SLT, 4, 1, 2));
      emit(ri(OP_SUBI, 5, 0, 1)); emit(ri(OP_SLTI, 6, 5, 5)); emit(rr(OP_SLT, 7, 1, 5)); emit(HLT_W);
      want_reg(3, 42); want_reg(5, 32'hFFFF_FFFF); want_reg(6, 0); want_reg(7, 1);
      close_vec(12, 8);

      // AND / OR
      open_vec();
      emit(ri(OP_ADDI, 1, 0, 12)); emit(ri(OP_ADDI, 2, 0, 10)); emit(rr(OP_AND, 3, 1, 2)); emit(rr(OP_OR, 4, 1, 2)); emit(HLT_W);
      want_reg(3, 8); want_reg(4, 14);
      close_vec(9, 5);

      for (int i = 0; i < nv; i++) run_vec(i);
      run_reset_midrun();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
